// File: rtl/seq_detect_ctrl_pkg.sv
// Shared encodings and defaults for the word-level "10" sequence detector controller.
package seq_detect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } ctrl_state_t;

  typedef enum logic [1:0] {
    DET_S0 = 2'b00,
    DET_S1 = 2'b01,
    DET_S2 = 2'b10,
    DET_S3 = 2'b11
  } det_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/seq_detect_ctrl_detector.sv
// Bit-serial Moore "10" detector with a synchronous clear; y is high only in s2.
module pat10_detector
  import seq_detect_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic x,
  output logic y
);

  det_state_t r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DET_S0;
    end else if (clr) begin
      r_state <= DET_S0;
    end else begin
      case (r_state)
        DET_S0:  r_state <= x ? DET_S1 : DET_S0;
        DET_S1:  r_state <= x ? DET_S1 : DET_S2;
        DET_S2:  r_state <= x ? DET_S1 : DET_S0;
        default: r_state <= DET_S0;
      endcase
    end
  end

  assign y = (r_state == DET_S2);

endmodule

// File: rtl/seq_detect_ctrl.sv
// Latches a word on start, feeds it MSB-first into the "10" detector and
// returns the saturating match count with a one-cycle done pulse.
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam int BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  ctrl_state_t      r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0] r_match;
  logic             r_busy;
  logic             r_done;

  logic w_accept;
  logic w_det_x;
  logic w_det_y;
  logic w_count;

  assign w_accept = (r_state == ST_IDLE) && start;
  // Detector only sees real data in SHIFT; DRAIN (and idle time) feed zeros.
  assign w_det_x  = (r_state == ST_SHIFT) && r_shift[WIDTH-1];
  assign w_count  = ((r_state == ST_SHIFT) || (r_state == ST_DRAIN))
                    && w_det_y && (r_match != CNT_MAX);

  pat10_detector u_det (
    .clk (clk),
    .rst (rst),
    .clr (w_accept),
    .x   (w_det_x),
    .y   (w_det_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_match   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift   <= data_in;
            r_bit_cnt <= '0;
            r_match   <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_count) r_match <= r_match + 1'b1;
          if (r_bit_cnt == LAST_BIT) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Last bit's match shows up on y only now, one cycle after its "0".
          if (w_count) r_match <= r_match + 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign match_count = r_match;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl (default build plus a CNT_W=2 build).
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, done;
  logic [3:0] match_count;
  logic       busy2, done2;
  logic [1:0] match_count2;

  int checks = 0;
  int failures = 0;

  int         rw_busy;
  int         rw_done;
  int         rw_done_idx;
  logic [3:0] rw_cnt;
  logic [1:0] rw_cnt2;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .match_count (match_count)
  );

  seq_detect_ctrl #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy2),
    .done        (done2),
    .match_count (match_count2)
  );

  // Stimulus only: starts a word at the next edge (E0) and samples #1 after E0..E10.
  // glitch_k >= 0 raises start with data_in=FF right after sample k.
  task automatic run_word(input logic [7:0] w, input int glitch_k);
    rw_busy = 0; rw_done = 0; rw_done_idx = -1; rw_cnt = 4'h0; rw_cnt2 = 2'h0;
    data_in = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data_in = ~w;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (busy) rw_busy++;
      if (done) begin
        rw_done++;
        if (rw_done_idx < 0) rw_done_idx = k;
        rw_cnt  = match_count;
        rw_cnt2 = match_count2;
      end
      if (k == glitch_k) begin
        start = 1'b1;
        data_in = 8'hFF;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (match_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", match_count); end
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || match_count !== 4'd0) begin
        failures++;
        $display("FAIL idle_cycle%0d busy=%b done=%b cnt=%0d exp busy=0 done=0 cnt=0", c, busy, done, match_count);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_alternating();
    run_word(8'b1010_1010, -1);
    checks++; if (rw_busy != 9) begin failures++; $display("FAIL aa_busy_cycles got=%0d exp=9", rw_busy); end
    checks++; if (rw_done != 1) begin failures++; $display("FAIL aa_done_pulses got=%0d exp=1", rw_done); end
    checks++; if (rw_done_idx != 9) begin failures++; $display("FAIL aa_done_edge got=%0d exp=9", rw_done_idx); end
    checks++; if (rw_cnt !== 4'd4) begin failures++; $display("FAIL aa_count got=%0d exp=4", rw_cnt); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL aa_after_done busy=%b done=%b exp 0 0", busy, done); end
    $display("word=aa count=%0d busy_cycles=%0d done_edge=%0d", rw_cnt, rw_busy, rw_done_idx);
  endtask

  task automatic test_patterns();
    run_word(8'b1111_0000, -1);
    checks++; if (rw_cnt !== 4'd1) begin failures++; $display("FAIL f0_count got=%0d exp=1", rw_cnt); end
    $display("word=f0 count=%0d", rw_cnt);
    run_word(8'b0000_0001, -1);
    checks++; if (rw_cnt !== 4'd0) begin failures++; $display("FAIL 01_count got=%0d exp=0", rw_cnt); end
    checks++; if (rw_done != 1) begin failures++; $display("FAIL 01_done_pulses got=%0d exp=1", rw_done); end
    $display("word=01 count=%0d", rw_cnt);
  endtask

  task automatic test_back_to_back();
    run_word(8'b0000_0001, -1);
    checks++; if (rw_cnt !== 4'd0 || rw_done != 1) begin failures++; $display("FAIL b2b_first count=%0d pulses=%0d exp 0 1", rw_cnt, rw_done); end
    $display("word=01 (b2b first) count=%0d", rw_cnt);
    run_word(8'b0111_1111, -1);
    checks++; if (rw_cnt !== 4'd0 || rw_done != 1) begin failures++; $display("FAIL b2b_second count=%0d pulses=%0d exp 0 1", rw_cnt, rw_done); end
    checks++; if (rw_done_idx != 9) begin failures++; $display("FAIL b2b_done_edge got=%0d exp=9", rw_done_idx); end
    $display("word=7f (b2b second) count=%0d", rw_cnt);
  endtask

  task automatic test_ignored_start();
    run_word(8'b1100_1100, 2);
    checks++; if (rw_cnt !== 4'd2) begin failures++; $display("FAIL ign_count got=%0d exp=2", rw_cnt); end
    checks++; if (rw_done != 1) begin failures++; $display("FAIL ign_done_pulses got=%0d exp=1", rw_done); end
    checks++; if (rw_busy != 9) begin failures++; $display("FAIL ign_busy_cycles got=%0d exp=9", rw_busy); end
    $display("word=cc with start at E3 count=%0d pulses=%0d", rw_cnt, rw_done);
  endtask

  task automatic test_reset_mid();
    int pulses;
    int busy_seen;
    data_in = 8'b1100_1100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || match_count !== 4'd1) begin failures++; $display("FAIL mid_pre_reset busy=%b cnt=%0d exp 1 1", busy, match_count); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_async_busy got=%b exp=0", busy); end
    checks++; if (match_count !== 4'd0) begin failures++; $display("FAIL mid_async_count got=%0d exp=0", match_count); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_async_done got=%b exp=0", done); end
    @(posedge clk); #1;
    rst = 1'b1;
    pulses = 0; busy_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", pulses); end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL mid_no_busy got=%0d exp=0", busy_seen); end
    run_word(8'b1000_0000, -1);
    checks++; if (rw_cnt !== 4'd1 || rw_done != 1) begin failures++; $display("FAIL mid_restart count=%0d pulses=%0d exp 1 1", rw_cnt, rw_done); end
    $display("reset mid-shift then word=80 count=%0d", rw_cnt);
  endtask

  task automatic test_saturation();
    run_word(8'b1010_1010, -1);
    checks++; if (rw_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_count got=%0d exp=3", rw_cnt2); end
    checks++; if (rw_cnt !== 4'd4) begin failures++; $display("FAIL sat_wide_count got=%0d exp=4", rw_cnt); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (match_count2 !== 2'd3 || match_count !== 4'd4) begin failures++; $display("FAIL sat_hold narrow=%0d wide=%0d exp 3 4", match_count2, match_count); end
    $display("word=aa narrow count=%0d wide count=%0d", rw_cnt2, rw_cnt);
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_patterns();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
